// File: rtl/branch_sequencer_pkg.sv
// Shared branch-type encodings, sequencer state encoding and ALU flag helpers
// for the registered branch sequencer and its single-cycle resolver.
package branch_sequencer_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BRZ  = 3'b001;
  localparam logic [2:0] BR_BMN  = 3'b010;
  localparam logic [2:0] BR_JM   = 3'b011;
  localparam logic [2:0] BR_BZ   = 3'b100;
  localparam logic [2:0] BR_BEQ  = 3'b101;

  // Widest datapath the flag helper accepts; callers zero-extend into it.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_UPD  = 2'd2
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
  } flags_t;

  function automatic flags_t derive_flags(input logic [MAX_W-1:0] val, input int unsigned w);
    flags_t             f;
    logic [MAX_W-1:0]   sign_bit;
    sign_bit = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    f.z      = (val == '0);
    f.n      = |(val & sign_bit);
    return f;
  endfunction

  function automatic logic needs_mem(input logic [2:0] br_type, input logic n);
    return (br_type == BR_JM) || ((br_type == BR_BMN) && n);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational next-PC/taken select from latched branch operands.
// Memory-indirect types take mem_data only when mem_ok_i says the read completed.
module branch_resolve
  import branch_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       br_type_i,
  input  logic             z_i,
  input  logic             n_i,
  input  logic             zero_branch_i,
  input  logic             mem_ok_i,
  input  logic [WIDTH-1:0] mem_data_i,
  input  logic [WIDTH-1:0] pc4_i,
  input  logic [WIDTH-1:0] reg1_i,
  input  logic [WIDTH-1:0] pcimm_i,
  input  logic [WIDTH-1:0] direct_i,
  output logic [WIDTH-1:0] target_o,
  output logic             taken_o
);

  always_comb begin
    target_o = pc4_i;
    taken_o  = 1'b0;
    case (br_type_i)
      BR_BRZ: if (z_i) begin
        target_o = reg1_i;
        taken_o  = 1'b1;
      end
      BR_BMN: if (n_i && mem_ok_i) begin
        target_o = mem_data_i;
        taken_o  = 1'b1;
      end
      BR_JM: if (mem_ok_i) begin
        target_o = mem_data_i;
        taken_o  = 1'b1;
      end
      BR_BZ: if (z_i) begin
        target_o = direct_i;
        taken_o  = 1'b1;
      end
      BR_BEQ: if (zero_branch_i) begin
        target_o = pcimm_i;
        taken_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Registered branch sequencer: IDLE -> (MEM) -> UPD, one pc_we per accepted branch,
// 1-cycle latency direct, ack+1 for memory-indirect; stall holds issue only while in MEM.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [2:0]       br_type,
  input  logic [WIDTH-1:0] aluout,
  input  logic             zero_branch,
  input  logic [WIDTH-1:0] pc4,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] pcimm,
  input  logic [WIDTH-1:0] direct,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             pc_we,
  output logic [WIDTH-1:0] pc_next,
  output logic             taken,
  output logic             stall,
  output logic             err_timeout,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int TMO_W = 8;

  state_e           state_q, state_d;
  logic [2:0]       type_q;
  logic             z_q, n_q, zb_q;
  logic [WIDTH-1:0] pc4_q, reg1_q, pcimm_q, direct_q, addr_q;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             mem_ok_q, mem_ok_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  flags_t           in_flags;
  logic             accept;
  logic             in_upd;
  logic [WIDTH-1:0] res_target;
  logic             res_taken;

  assign in_flags = derive_flags(MAX_W'(aluout), WIDTH);
  // A new branch is taken in IDLE and also in the UPD cycle, giving back-to-back issue.
  assign accept   = br_valid && (state_q != ST_MEM);
  assign in_upd   = (state_q == ST_UPD);

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    mem_ok_d = mem_ok_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_MEM: begin
        if (mem_ack) begin
          rdata_d  = mem_rdata;
          mem_ok_d = 1'b1;
          state_d  = ST_UPD;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          mem_ok_d = 1'b0;
          state_d  = ST_UPD;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          tmo_d    = '0;
          mem_ok_d = 1'b0;
          state_d  = needs_mem(br_type, in_flags.n) ? ST_MEM : ST_UPD;
        end
      end
    endcase
    if (in_upd && res_taken && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tmo_q    <= '0;
      mem_ok_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      mem_ok_q <= mem_ok_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      type_q   <= BR_NONE;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      zb_q     <= 1'b0;
      pc4_q    <= '0;
      reg1_q   <= '0;
      pcimm_q  <= '0;
      direct_q <= '0;
      addr_q   <= '0;
    end else if (accept) begin
      type_q   <= br_type;
      z_q      <= in_flags.z;
      n_q      <= in_flags.n;
      zb_q     <= zero_branch;
      pc4_q    <= pc4;
      reg1_q   <= reg1;
      pcimm_q  <= pcimm;
      direct_q <= direct;
      addr_q   <= aluout;
    end
  end

  branch_resolve #(.WIDTH(WIDTH)) u_resolve (
    .br_type_i     (type_q),
    .z_i           (z_q),
    .n_i           (n_q),
    .zero_branch_i (zb_q),
    .mem_ok_i      (mem_ok_q),
    .mem_data_i    (rdata_q),
    .pc4_i         (pc4_q),
    .reg1_i        (reg1_q),
    .pcimm_i       (pcimm_q),
    .direct_i      (direct_q),
    .target_o      (res_target),
    .taken_o       (res_taken)
  );

  assign mem_req     = (state_q == ST_MEM);
  assign stall       = (state_q == ST_MEM);
  assign mem_addr    = addr_q;
  assign pc_we       = in_upd;
  assign pc_next     = in_upd ? res_target : '0;
  assign taken       = in_upd & res_taken;
  assign err_timeout = err_q;
  assign taken_cnt   = cnt_q;

  a_no_issue_while_stalled: assert property (@(posedge clk) disable iff (reset) !(br_valid && stall));

endmodule
